// File: rtl/vga_capture.sv
// Passive VGA stream receiver: recovers pixel coordinates, strobes each visible pixel,
// checks frame geometry and accumulates a per-frame 16-bit colour checksum.
module vga_capture #(
   parameter int REG_SIZE = 8,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    vga_clk,
   input  logic                    h_sync,
   input  logic                    v_sync,
   input  logic                    blank_n,
   input  logic [REG_SIZE-1:0]     red_vga,
   input  logic [REG_SIZE-1:0]     green_vga,
   input  logic [REG_SIZE-1:0]     blue_vga,
   output logic                    pix_valid,
   output logic [9:0]              pix_x,
   output logic [9:0]              pix_y,
   output logic [3*REG_SIZE-1:0]   pix_rgb,
   output logic                    frame_start,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic [15:0]             checksum,
   output logic [15:0]             frame_count
);

   typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_ACTIVE} state_t;

   localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
   localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);
   localparam logic [9:0] LP_SAT      = 10'h3FF;

   state_t      r_state;
   logic        r_vga_clk_q;
   logic        r_blank_q;
   logic        r_line_err;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [15:0] r_sum;

   logic        w_tick;
   logic        w_in_window;
   logic [9:0]  w_x_inc;
   logic [9:0]  w_y_inc;
   logic [15:0] w_pix_sum;

   // vga_clk is a divided copy of clk, so its rising edge is found by sampling it as data.
   assign w_tick      = vga_clk & ~r_vga_clk_q;
   assign w_in_window = (r_x < LP_H_ACTIVE) && (r_y < LP_V_ACTIVE);
   assign w_x_inc     = (r_x == LP_SAT) ? r_x : r_x + 10'd1;
   assign w_y_inc     = (r_y == LP_SAT) ? r_y : r_y + 10'd1;
   assign w_pix_sum   = 16'(red_vga) + 16'(green_vga) + 16'(blue_vga);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_vga_clk_q <= 1'b0;
         r_blank_q   <= 1'b0;
         r_line_err  <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_sum       <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         checksum    <= '0;
         frame_count <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every branch below sees the pre-edge x/y/sum.
         r_vga_clk_q <= vga_clk;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         if (w_tick) r_blank_q <= blank_n;

         if (!en) begin
            r_state <= S_IDLE;
         end else if (w_tick) begin
            case (r_state)
               S_IDLE: if (!v_sync) r_state <= S_VSYNC;
               S_VSYNC: begin
                  if (v_sync) begin
                     r_x         <= '0;
                     r_y         <= '0;
                     r_sum       <= '0;
                     r_line_err  <= 1'b0;
                     frame_start <= 1'b1;
                     r_state     <= S_ACTIVE;
                  end
               end
               S_ACTIVE: begin
                  // v_sync low wins over a visible pixel in the same tick.
                  if (!v_sync) begin
                     frame_done  <= 1'b1;
                     frame_err   <= r_line_err | (r_y != LP_V_ACTIVE);
                     checksum    <= r_sum;
                     frame_count <= frame_count + 16'd1;
                     r_state     <= S_VSYNC;
                  end else if (blank_n) begin
                     if (w_in_window) begin
                        pix_valid <= 1'b1;
                        pix_x     <= r_x;
                        pix_y     <= r_y;
                        pix_rgb   <= {red_vga, green_vga, blue_vga};
                        r_sum     <= r_sum + w_pix_sum;
                     end
                     if (!w_in_window || !h_sync) r_line_err <= 1'b1;
                     r_x <= w_x_inc;
                  end else if (r_blank_q) begin
                     if (r_x != LP_H_ACTIVE) r_line_err <= 1'b1;
                     r_x <= '0;
                     r_y <= w_y_inc;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: 4x3 frames, vga_clk = clk/2, expected pixels queued at drive time.
module tb_vga_capture;

   logic        clk;
   logic        reset;
   logic        en;
   logic        vga_clk;
   logic        h_sync;
   logic        v_sync;
   logic        blank_n;
   logic [7:0]  red_vga;
   logic [7:0]  green_vga;
   logic [7:0]  blue_vga;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [23:0] pix_rgb;
   logic        frame_start;
   logic        frame_done;
   logic        frame_err;
   logic [15:0] checksum;
   logic [15:0] frame_count;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] rgb;
   } pix_t;

   pix_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fs     = 0;
   int   n_fd     = 0;
   int   n_pix    = 0;
   logic prev_pv  = 1'b0;

   vga_capture #(.REG_SIZE(8), .H_ACTIVE(4), .V_ACTIVE(3)) dut (
      .clk(clk), .reset(reset), .en(en), .vga_clk(vga_clk),
      .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
      .red_vga(red_vga), .green_vga(green_vga), .blue_vga(blue_vga),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
      .checksum(checksum), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: pops the scoreboard on every strobe and counts frame pulses.
   always @(negedge clk) begin
      if (pix_valid) begin
         pix_t e;
         n_pix++;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL pix_unexpected: got (%0d,%0d) rgb=%h, required no strobe", pix_x, pix_y, pix_rgb);
         end else begin
            e = exp_q.pop_front();
            if ({pix_x, pix_y, pix_rgb} !== {e.x, e.y, e.rgb})
               $display("FAIL pix_data: got (%0d,%0d) rgb=%h, required (%0d,%0d) rgb=%h",
                        pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb);
            else n_pass++;
         end
         n_checks++;
         if (prev_pv !== 1'b0) $display("FAIL pix_back_to_back: got consecutive strobes, required gap");
         else n_pass++;
      end
      if (frame_start) n_fs++;
      if (frame_done)  n_fd++;
      prev_pv = pix_valid;
   end

   // One pixel-clock period (two clk cycles) with the given line levels.
   task automatic drive(input logic hs, input logic vs, input logic bn, input logic [7:0] r);
      @(negedge clk);
      vga_clk   = 1'b1;
      h_sync    = hs;
      v_sync    = vs;
      blank_n   = bn;
      red_vga   = r;
      green_vga = 8'h00;
      blue_vga  = 8'h00;
      @(negedge clk);
      vga_clk   = 1'b0;
   endtask

   task automatic vsync_pulse();
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   // Back porch, lines, front porch, then the next v_sync low that ends the frame.
   task automatic run_frame(input int n_lines, input int long_line, input bit capture,
                            input int drop_after, input bit late_en);
      bit cap;
      int seen;
      cap  = capture;
      seen = 0;
      if (late_en) en = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      if (late_en) en = 1'b1;
      for (int y = 0; y < n_lines; y++) begin
         for (int x = 0; x < ((y == long_line) ? 5 : 4); x++) begin
            drive(1'b1, 1'b1, 1'b1, 8'(4 * y + x));
            if (cap && x < 4 && y < 3) exp_q.push_back('{10'(x), 10'(y), {8'(4 * y + x), 16'h0000}});
            seen++;
            if (seen == drop_after) begin
               en = 1'b0;
               repeat (10) @(negedge clk);
               en  = 1'b1;
               cap = 1'b0;
            end
         end
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         drive(1'b1, 1'b1, 1'b0, 8'h00);
      end
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      vsync_pulse();
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; vga_clk = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
      blank_n = 1'b0; red_vga = '0; green_vga = '0; blue_vga = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done, frame_err, checksum, frame_count} !== '0)
         $display("FAIL reset_outputs: got nonzero outputs, required all 0");
      else n_pass++;
      reset = 1'b1;
   endtask

   task automatic test_nominal();
      int fs0, fd0;
      fs0 = n_fs; fd0 = n_fd;
      vsync_pulse();
      run_frame(3, -1, 1'b1, -1, 1'b0);
      n_checks++; if (exp_q.size() !== 0) $display("FAIL nom_pix_left: got %0d pending, required 0", exp_q.size()); else n_pass++;
      n_checks++; if (n_fs - fs0 !== 1) $display("FAIL nom_frame_start: got %0d, required 1", n_fs - fs0); else n_pass++;
      n_checks++; if (n_fd - fd0 !== 1) $display("FAIL nom_frame_done: got %0d, required 1", n_fd - fd0); else n_pass++;
      n_checks++; if (checksum !== 16'd66) $display("FAIL nom_checksum: got %0d, required 66", checksum); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("FAIL nom_frame_err: got %0b, required 0", frame_err); else n_pass++;
      n_checks++; if (frame_count !== 16'd1) $display("FAIL nom_frame_count: got %0d, required 1", frame_count); else n_pass++;
   endtask

   task automatic test_long_line();
      run_frame(3, 1, 1'b1, -1, 1'b0);
      n_checks++; if (exp_q.size() !== 0) $display("FAIL long_pix_left: got %0d pending, required 0", exp_q.size()); else n_pass++;
      n_checks++; if (frame_err !== 1'b1) $display("FAIL long_frame_err: got %0b, required 1", frame_err); else n_pass++;
      n_checks++; if (checksum !== 16'd66) $display("FAIL long_checksum: got %0d, required 66", checksum); else n_pass++;
      run_frame(3, -1, 1'b1, -1, 1'b0);
      n_checks++; if (frame_err !== 1'b0) $display("FAIL clean_frame_err: got %0b, required 0", frame_err); else n_pass++;
      n_checks++; if (frame_count !== 16'd3) $display("FAIL clean_frame_count: got %0d, required 3", frame_count); else n_pass++;
   endtask

   task automatic test_short_frame();
      int p0;
      p0 = n_pix;
      run_frame(2, -1, 1'b1, -1, 1'b0);
      n_checks++; if (n_pix - p0 !== 8) $display("FAIL short_pix_count: got %0d, required 8", n_pix - p0); else n_pass++;
      n_checks++; if (frame_err !== 1'b1) $display("FAIL short_frame_err: got %0b, required 1", frame_err); else n_pass++;
      n_checks++; if (checksum !== 16'd28) $display("FAIL short_checksum: got %0d, required 28", checksum); else n_pass++;
   endtask

   task automatic test_mid_enable();
      int p0, fd0;
      p0 = n_pix; fd0 = n_fd;
      run_frame(3, -1, 1'b0, -1, 1'b1);
      n_checks++; if (n_pix - p0 !== 0) $display("FAIL midon_pix_count: got %0d, required 0", n_pix - p0); else n_pass++;
      n_checks++; if (n_fd - fd0 !== 0) $display("FAIL midon_frame_done: got %0d, required 0", n_fd - fd0); else n_pass++;
      n_checks++; if (frame_count !== 16'd4) $display("FAIL midon_count_held: got %0d, required 4", frame_count); else n_pass++;
      run_frame(3, -1, 1'b1, -1, 1'b0);
      n_checks++; if (checksum !== 16'd66) $display("FAIL midon_checksum: got %0d, required 66", checksum); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("FAIL midon_frame_err: got %0b, required 0", frame_err); else n_pass++;
      n_checks++; if (frame_count !== 16'd5) $display("FAIL midon_frame_count: got %0d, required 5", frame_count); else n_pass++;
   endtask

   task automatic test_en_drop();
      int fd0;
      fd0 = n_fd;
      run_frame(3, -1, 1'b1, 5, 1'b0);
      n_checks++; if (exp_q.size() !== 0) $display("FAIL drop_pix_left: got %0d pending, required 0", exp_q.size()); else n_pass++;
      n_checks++; if (n_fd - fd0 !== 0) $display("FAIL drop_frame_done: got %0d, required 0", n_fd - fd0); else n_pass++;
      n_checks++; if (frame_count !== 16'd5) $display("FAIL drop_count_held: got %0d, required 5", frame_count); else n_pass++;
      n_checks++; if (checksum !== 16'd66) $display("FAIL drop_checksum_held: got %0d, required 66", checksum); else n_pass++;
      run_frame(3, -1, 1'b1, -1, 1'b0);
      n_checks++; if (checksum !== 16'd66) $display("FAIL drop_next_checksum: got %0d, required 66", checksum); else n_pass++;
      n_checks++; if (frame_count !== 16'd6) $display("FAIL drop_next_count: got %0d, required 6", frame_count); else n_pass++;
   endtask

   task automatic test_reset_mid_line();
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      exp_q.push_back('{10'd0, 10'd0, 24'h000000});
      drive(1'b1, 1'b1, 1'b1, 8'h01);
      exp_q.push_back('{10'd1, 10'd0, 24'h010000});
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done, frame_err, checksum, frame_count} !== '0)
         $display("FAIL rst_async_outputs: got x=%0d count=%0d sum=%0d, required all 0", pix_x, frame_count, checksum);
      else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL rst_pix_left: got %0d pending, required 0", exp_q.size()); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      vsync_pulse();
      run_frame(3, -1, 1'b1, -1, 1'b0);
      n_checks++; if (frame_count !== 16'd1) $display("FAIL rst_frame_count: got %0d, required 1", frame_count); else n_pass++;
      n_checks++; if (checksum !== 16'd66) $display("FAIL rst_checksum: got %0d, required 66", checksum); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_long_line();
      test_short_frame();
      test_mid_enable();
      test_en_drop();
      test_reset_mid_line();
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
